// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
// The FSM encodings stay plain logic constants so older tools can consume them.
package fetch_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam logic [31:0]  INST_NOP = 32'h0000_0013;
    localparam int unsigned  PC_STEP  = 4;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory port, redirect input and decoder port.
// The master side is the fetch unit; the slave side is memory plus the decoder.
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instruction, pc} pairs with a registered head stage.
// A pushed entry reaches the head one edge after it is written.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic                   head_vld,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             head_vld_q, head_vld_d;
    logic             do_push, do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && head_vld_q && !flush;

    // Head is loaded from pre-edge storage but already accounts for this edge's pop,
    // so a popped entry is never shown twice.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + AW'(do_push);
        rd_ptr_d   = rd_ptr_q + AW'(do_pop);
        count_d    = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        head_vld_d = (count_q - (AW+1)'(do_pop)) != '0;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            head_vld_d = 1'b0;
        end
        head_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign head_vld = head_vld_q;
    assign head     = head_q;
    assign count    = count_q;
    assign full     = count_q == (AW+1)'(DEPTH);
    assign empty    = count_q == '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front-end: owns the fetch PC, keeps one request in flight to instruction
// memory and buffers returned words for the decoder; redirects flush everything.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]        state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty;
    logic              head_vld;
    logic [2*XLEN-1:0] head;
    logic              redirect, outstanding, credit, push, pop;

    assign redirect    = bus.redirect_valid;
    assign outstanding = (state_q == WAIT) || (state_q == DRAIN);
    // Counting the in-flight word against capacity is what makes a push into a full FIFO impossible.
    assign credit      = (fifo_count + CW'(outstanding)) < CW'(DEPTH);
    assign push        = (state_q == WAIT) && bus.imem_rvalid && !redirect;
    assign pop         = bus.inst_ready && head_vld && !redirect;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        case (state_q)
            IDLE: if (credit) state_d = REQ;
            REQ: begin
                if (bus.imem_ready) begin
                    fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
                    req_pc_d   = fetch_pc_q;
                    state_d    = WAIT;
                end
            end
            WAIT, DRAIN: if (bus.imem_rvalid) state_d = credit ? REQ : IDLE;
            default: state_d = IDLE;
        endcase
        if (redirect) begin
            fetch_pc_d = bus.redirect_pc & ~XLEN'(3);
            // A request still owed a response must have that response drained first.
            if ((state_q == REQ && bus.imem_ready) || (outstanding && !bus.imem_rvalid))
                state_d = DRAIN;
            else
                state_d = REQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(2*XLEN)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect),
        .push     (push),
        .wdata    ({bus.imem_rdata, req_pc_q}),
        .pop      (pop),
        .head_vld (head_vld),
        .head     (head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign bus.imem_req   = state_q == REQ;
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.inst_valid = head_vld;
    assign bus.inst       = head[2*XLEN-1:XLEN];
    assign bus.inst_pc    = head[XLEN-1:0];

    a_rvalid_expected: assert property (@(posedge clk) disable iff (!rst_n)
        bus.imem_rvalid |-> outstanding);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (!fifo_full || pop));
    a_head_backed: assert property (@(posedge clk) disable iff (!rst_n)
        head_vld |-> !fifo_empty);

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage that feeds the decoder.
- Owns the fetch PC and issues word requests to a variable-latency instruction memory over a req/ready + rvalid handshake.
- Buffers returned instructions with their PCs in a small prefetch FIFO, presented downstream over valid/ready.
- Accepts a redirect (taken branch/jump target) that flushes buffered and in-flight instructions.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- DEPTH, 4: prefetch FIFO entries. Power of two, at least 2.
- XLEN, 32: address/instruction width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  word-aligned fetch address.
- imem_ready  in  1  memory accepts request this cycle when imem_req=1.
- imem_rvalid  in  1  response valid, one per accepted request, in order, at least 1 cycle after acceptance.
- imem_rdata  in  XLEN  returned instruction.
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  XLEN  new fetch address; bits[1:0] ignored (treated as 0).
- inst_valid  out  1  FIFO head holds a valid instruction.
- inst  out  XLEN  head instruction.
- inst_pc  out  XLEN  address of head instruction.
- inst_ready  in  1  consumer takes head this cycle when inst_valid=1.

Behaviour:
- Reset (async assert, sync-deasserted externally): fetch_pc=RESET_PC, FIFO empty, state=IDLE, imem_req=0, inst_valid=0, inst/inst_pc=0.
- Outstanding limit is one request. Credit check: request is issued only when (fifo_count + outstanding) < DEPTH.
- FSM states:
  - IDLE: imem_req=0. Go to REQ when credit is available.
  - REQ: imem_req=1, imem_addr=fetch_pc. On imem_ready: fetch_pc += 4, record req_pc, go to WAIT. While not accepted, hold req and addr stable, except on redirect.
  - WAIT: imem_req=0. On imem_rvalid: push {imem_rdata, req_pc}, then go to REQ if credit remains, else IDLE.
  - DRAIN: an in-flight response is stale. On imem_rvalid: discard the response, then go to REQ or IDLE per credit.
- Redirect (highest priority, same cycle):
  - FIFO is flushed; count=0 next cycle.
  - fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - Any push and any pop that cycle are suppressed.
  - Next state: from WAIT, or from REQ with imem_ready=1 this cycle → DRAIN. Redirect that coincides with rvalid in WAIT → response dropped, next state REQ. Otherwise → REQ.
  - DRAIN + redirect: stays DRAIN and updates fetch_pc. If rvalid arrives the same cycle, the stale response is consumed and next state is REQ.
  - REQ not yet accepted: imem_addr changes to the new PC next cycle. Memory must tolerate address change on an unaccepted request.
- FIFO:
  - Push and pop in the same cycle are allowed and count is unchanged; also legal when full, since the credit rule guarantees no overflow.
  - Pop when empty is ignored.
  - Pointers wrap modulo DEPTH.
  - Head outputs are registered-read from storage, so an instruction becomes visible 1 cycle after its rvalid.
- Latency: reset release → first imem_req in cycle 1 (IDLE→REQ takes one edge). rvalid at edge N → inst_valid at edge N+1.
- fetch_pc wraps from 32'hFFFF_FFFC to 0 without error.
- imem_rvalid in IDLE/REQ is a protocol violation. Simulation asserts it; RTL ignores it.

Decomposition:
- Shared package fetch_pkg:
  - state enum {IDLE, REQ, WAIT, DRAIN}.
  - INST_NOP = 32'h0000_0013.
  - PC_STEP = 4.
- One sub-module: fetch_fifo (DEPTH×(2·XLEN) sync FIFO with flush, count, full/empty). The FSM and PC logic stay in the top.

Test Plan:
- Straight-line run: memory with 2-cycle latency, inst_ready=1 → inst_pc sequence 0,4,8,C… with inst equal to the memory contents, one instruction per 3 cycles.
- Back-pressure: inst_ready=0 for 20 cycles, 1-cycle memory → exactly 4 entries buffered, imem_req stays 0 once credit is exhausted. Then ready=1 → 0,4,8,C drained in order with no loss.
- Redirect in WAIT: redirect_pc=0x100 while the 0x8 request is in flight → 0x8 response dropped; next inst_pc=0x100, and no 0x8 or 0xC appears.
- Redirect coinciding with rvalid and inst_ready=1 → no pop or push that cycle; FIFO empty; next fetch addr=0x100.
- Misaligned redirect 0x203 → imem_addr=0x200.
- Async reset asserted mid-WAIT → outputs zero immediately; after release, first imem_addr=RESET_PC and the late stale rvalid is ignored.
